// File: rtl/disp_sched_pkg.sv
// Shared types and helpers for the disparity cost scheduler.
// Optional feature macro: DISP_UNIQUENESS_EN (second-best uniqueness check).
package disp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Widest all-ones cost; modules take the low CW bits as their "no cost yet" value.
  localparam logic [31:0] COST_MAX = 32'hFFFF_FFFF;

  // A hamming distance over w bits ranges 0..w, so it needs clog2(w+1) bits.
  function automatic int cost_width(input int census_width);
    return $clog2(census_width + 1);
  endfunction

  // Disparity index 0..max_disp-1.
  function automatic int disp_width(input int max_disp);
    return $clog2(max_disp);
  endfunction

endpackage

// File: rtl/disparity_cost_scheduler_wta_tracker.sv
// Winner-take-all tracker: keeps the lowest cost seen and its disparity.
// With DISP_UNIQUENESS_EN it also tracks the lowest cost at any other
// disparity and flags results whose winning margin is too small.
module wta_tracker
  import disp_sched_pkg::*;
#(
  parameter int CW          = 4,
  parameter int DW          = 4,
  parameter int UNIQ_MARGIN = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          valid,
  input  logic [CW-1:0] cost,
  input  logic [DW-1:0] index,
  output logic [CW-1:0] next_best_cost,
  output logic [DW-1:0] next_best_d,
  output logic          unique_fail
);

  logic [CW-1:0] best_cost;
  logic [DW-1:0] best_d;

  if (UNIQ_MARGIN < 0) begin : g_bad_margin
    $error("wta_tracker: UNIQ_MARGIN must be non-negative");
  end

  // Strict less-than so that ties keep the earlier (lower) disparity.
  always_comb begin
    next_best_cost = best_cost;
    next_best_d    = best_d;
    if (valid && (cost < best_cost)) begin
      next_best_cost = cost;
      next_best_d    = index;
    end
  end

  // Best-so-far registers, restarted for every new pixel.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      best_cost <= COST_MAX[CW-1:0];
      best_d    <= '0;
    end else begin
      best_cost <= next_best_cost;
      best_d    <= next_best_d;
    end
  end

`ifdef DISP_UNIQUENESS_EN
  logic [CW-1:0] second_cost;
  logic [CW-1:0] next_second;
  logic [CW:0]   gap;

  // A displaced winner becomes the runner-up; otherwise a cheaper loser does.
  always_comb begin
    next_second = second_cost;
    if (valid) begin
      if (cost < best_cost) begin
        next_second = best_cost;
      end else if (cost < second_cost) begin
        next_second = cost;
      end
    end
    gap         = {1'b0, next_second} - {1'b0, next_best_cost};
    unique_fail = (int'(gap) < UNIQ_MARGIN);
  end

  // Runner-up register, restarted with the best-so-far.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      second_cost <= COST_MAX[CW-1:0];
    end else begin
      second_cost <= next_second;
    end
  end
`else
  // Without the uniqueness check only the watchdog can invalidate a result.
  always_comb begin
    unique_fail = 1'b0;
  end
`endif

endmodule

// File: rtl/disparity_cost_scheduler.sv
// Per-pixel disparity search sequencer around a shared hamming pipeline.
// Issues one census comparison per cycle, collects costs in issue order,
// picks the winner and hands it downstream on a valid/ready handshake.
// Optional feature macro: DISP_UNIQUENESS_EN (see wta_tracker).
module disparity_cost_scheduler
  import disp_sched_pkg::*;
#(
  parameter  int CENSUS_WIDTH = 8,
  parameter  int MAX_DISP     = 16,
  parameter  int HD_LAT       = 4,
  parameter  int UNIQ_MARGIN  = 1,
  localparam int CW           = cost_width(CENSUS_WIDTH),
  localparam int DW           = disp_width(MAX_DISP)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [CENSUS_WIDTH-1:0]          s_census_left,
  input  logic [MAX_DISP*CENSUS_WIDTH-1:0] s_census_right,
  output logic [CENSUS_WIDTH-1:0]          hd_census_left,
  output logic [CENSUS_WIDTH-1:0]          hd_census_right,
  output logic                             hd_valid_in,
  input  logic [CW-1:0]                    hd_dist,
  input  logic                             hd_valid_out,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [DW-1:0]                    m_disparity,
  output logic [CW-1:0]                    m_cost,
  output logic                             m_invalid,
  output logic                             err_drain
);

  localparam int            DRW         = $clog2(HD_LAT + 3);
  localparam logic [DRW-1:0] DRAIN_LIMIT = DRW'(HD_LAT + 2);
  localparam logic [DW-1:0]  LAST_D      = DW'(MAX_DISP - 1);

  if (MAX_DISP < 2) begin : g_bad_disp
    $error("disparity_cost_scheduler: MAX_DISP must be at least 2");
  end

  state_t                           state;
  state_t                           next_state;
  logic [MAX_DISP*CENSUS_WIDTH-1:0] cand_reg;
  logic [DW-1:0]                    issue_cnt;
  logic [DW-1:0]                    next_issue;
  logic [DW-1:0]                    ret_cnt;
  logic [DRW-1:0]                   drain_cnt;
  logic                             accept;
  logic                             issue_last;
  logic                             collect;
  logic                             complete;
  logic                             timeout;
  logic [CW-1:0]                    next_best_cost;
  logic [DW-1:0]                    next_best_d;
  logic                             unique_fail;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = ISSUE;
      ISSUE:   if (issue_last) next_state = DRAIN;
      DRAIN:   if (complete || timeout) next_state = DONE;
      DONE:    if (m_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Control decode; results returning outside ISSUE/DRAIN are dropped.
  always_comb begin
    s_ready    = (state == IDLE) && !rst;
    m_valid    = (state == DONE);
    accept     = s_valid && s_ready;
    issue_last = (state == ISSUE) && (issue_cnt == LAST_D);
    collect    = ((state == ISSUE) || (state == DRAIN)) && hd_valid_out;
    complete   = (state == DRAIN) && collect && (ret_cnt == LAST_D);
    timeout    = (state == DRAIN) && !complete && (drain_cnt >= DRAIN_LIMIT);
    next_issue = issue_cnt + DW'(1);
  end

  // Issue side: registered operands, candidate 0 is presented straight from the accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      hd_valid_in     <= 1'b0;
      hd_census_left  <= '0;
      hd_census_right <= '0;
      issue_cnt       <= '0;
    end else if (accept) begin
      hd_valid_in     <= 1'b1;
      hd_census_left  <= s_census_left;
      hd_census_right <= s_census_right[CENSUS_WIDTH-1:0];
      issue_cnt       <= '0;
    end else if (state == ISSUE) begin
      if (issue_last) begin
        hd_valid_in <= 1'b0;
      end else begin
        issue_cnt       <= next_issue;
        hd_census_right <= cand_reg[int'(next_issue)*CENSUS_WIDTH +: CENSUS_WIDTH];
      end
    end
  end

  // Candidate store, only meaningful between accept and the last issue.
  always_ff @(posedge clk) begin
    if (accept) begin
      cand_reg <= s_census_right;
    end
  end

  // Return counter (doubles as result disparity) and drain watchdog counter.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      ret_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      if (collect) begin
        ret_cnt <= ret_cnt + DW'(1);
      end
      if (issue_last) begin
        drain_cnt <= '0;
      end else if (state == DRAIN) begin
        drain_cnt <= drain_cnt + DRW'(1);
      end
    end
  end

  // Result capture on the finishing edge, including the cost absorbed on that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_disparity <= '0;
      m_cost      <= '0;
      m_invalid   <= 1'b0;
      err_drain   <= 1'b0;
    end else if (complete || timeout) begin
      m_disparity <= next_best_d;
      m_cost      <= next_best_cost;
      m_invalid   <= timeout || unique_fail;
      if (timeout) begin
        err_drain <= 1'b1;
      end
    end
  end

  wta_tracker #(
    .CW          (CW),
    .DW          (DW),
    .UNIQ_MARGIN (UNIQ_MARGIN)
  ) u_wta (
    .clk            (clk),
    .rst            (rst),
    .clear          (accept),
    .valid          (collect),
    .cost           (hd_dist),
    .index          (ret_cnt),
    .next_best_cost (next_best_cost),
    .next_best_d    (next_best_d),
    .unique_fail    (unique_fail)
  );

endmodule

// File: tb/tb_disparity_cost_scheduler.sv
// Self-checking bench for disparity_cost_scheduler with a behavioural
// hamming pipeline and an argmin reference model over whole pixels.
module tb_disparity_cost_scheduler;

  localparam int CENSUS_WIDTH = 8;
  localparam int MAX_DISP     = 16;
  localparam int HD_LAT       = 4;
  localparam int UNIQ_MARGIN  = 1;
  localparam int CW           = 4;
  localparam int DW           = 4;

  logic                             clk = 1'b0;
  logic                             rst;
  logic                             s_valid;
  logic                             s_ready;
  logic [CENSUS_WIDTH-1:0]          s_census_left;
  logic [MAX_DISP*CENSUS_WIDTH-1:0] s_census_right;
  logic [CENSUS_WIDTH-1:0]          hd_census_left;
  logic [CENSUS_WIDTH-1:0]          hd_census_right;
  logic                             hd_valid_in;
  logic [CW-1:0]                    hd_dist;
  logic                             hd_valid_out;
  logic                             m_valid;
  logic                             m_ready;
  logic [DW-1:0]                    m_disparity;
  logic [CW-1:0]                    m_cost;
  logic                             m_invalid;
  logic                             err_drain;

  int passed = 0;
  int total  = 0;

  logic [7:0] pix_left;
  logic [7:0] pix_right [MAX_DISP];
  int         suppress_idx = -1;

  // Behavioural hamming unit state.
  logic          pv   [HD_LAT];
  logic [CW-1:0] pd   [HD_LAT];
  int            pidx [HD_LAT];
  int            issue_seen;

  disparity_cost_scheduler #(
    .CENSUS_WIDTH (CENSUS_WIDTH),
    .MAX_DISP     (MAX_DISP),
    .HD_LAT       (HD_LAT),
    .UNIQ_MARGIN  (UNIQ_MARGIN)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_census_left   (s_census_left),
    .s_census_right  (s_census_right),
    .hd_census_left  (hd_census_left),
    .hd_census_right (hd_census_right),
    .hd_valid_in     (hd_valid_in),
    .hd_dist         (hd_dist),
    .hd_valid_out    (hd_valid_out),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_disparity     (m_disparity),
    .m_cost          (m_cost),
    .m_invalid       (m_invalid),
    .err_drain       (err_drain)
  );

  always #5 clk = ~clk;

  // Hamming pipeline: HD_LAT stages, reset by the same edge as the scheduler.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < HD_LAT; i++) begin
        pv[i]   <= 1'b0;
        pd[i]   <= '0;
        pidx[i] <= 0;
      end
      issue_seen <= 0;
    end else begin
      for (int i = HD_LAT - 1; i > 0; i--) begin
        pv[i]   <= pv[i-1];
        pd[i]   <= pd[i-1];
        pidx[i] <= pidx[i-1];
      end
      pv[0]   <= hd_valid_in;
      pd[0]   <= CW'($countones(hd_census_left ^ hd_census_right));
      pidx[0] <= issue_seen;
      if (hd_valid_in) issue_seen <= (issue_seen + 1) % MAX_DISP;
    end
  end

  assign hd_valid_out = pv[HD_LAT-1] && (pidx[HD_LAT-1] != suppress_idx);
  assign hd_dist      = pd[HD_LAT-1];

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: argmin of per-candidate hamming cost, lowest index on ties.
  task automatic model(output int ed, output int ec, output bit einv);
    int cost [MAX_DISP];
    int best;
    int second;
    best = -1;
    for (int d = 0; d < MAX_DISP; d++) cost[d] = $countones(pix_left ^ pix_right[d]);
    for (int d = 0; d < MAX_DISP; d++)
      if (d != suppress_idx && (best < 0 || cost[d] < cost[best])) best = d;
    second = (1 << CW) - 1;
    for (int d = 0; d < MAX_DISP; d++)
      if (d != suppress_idx && d != best && cost[d] < second) second = cost[d];
    ed   = best;
    ec   = cost[best];
    einv = (suppress_idx >= 0);
`ifdef DISP_UNIQUENESS_EN
    if (second - ec < UNIQ_MARGIN) einv = 1'b1;
`endif
  endtask

  // Drives one pixel from a negedge, waits for the result, optionally stalls m_ready.
  task automatic apply_stimulus(input string tag, input int hold, input bit expect_immediate);
    int  ed, ec, n, wait_n, hv_cnt, hv_first;
    bit  einv;
    model(ed, ec, einv);
    s_valid       = 1'b1;
    s_census_left = pix_left;
    for (int d = 0; d < MAX_DISP; d++) s_census_right[d*CENSUS_WIDTH +: CENSUS_WIDTH] = pix_right[d];
    wait_n = 0;
    while (!s_ready && wait_n < 100) begin
      @(negedge clk);
      wait_n++;
    end
    if (expect_immediate) check_output({tag, "_accept_wait"}, wait_n, 0);
    @(posedge clk);
    @(negedge clk);
    s_valid  = 1'b0;
    n        = 1;
    hv_cnt   = 0;
    hv_first = 0;
    while (!m_valid && n < 64) begin
      if (hd_valid_in) begin
        if (hv_cnt == 0) hv_first = n;
        hv_cnt++;
      end
      @(negedge clk);
      n++;
    end
    check_output({tag, "_m_valid"}, m_valid, 1);
    if (suppress_idx < 0) begin
      check_output({tag, "_latency"}, n, MAX_DISP + HD_LAT + 1);
      check_output({tag, "_issue_cnt"}, hv_cnt, MAX_DISP);
      check_output({tag, "_issue_first"}, hv_first, 1);
    end
    check_output({tag, "_disp"}, m_disparity, ed);
    check_output({tag, "_cost"}, m_cost, ec);
    check_output({tag, "_invalid"}, m_invalid, einv);
    if (hold > 0) s_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_output({tag, "_hold_valid"}, m_valid, 1);
      check_output({tag, "_hold_s_ready"}, s_ready, 0);
      check_output({tag, "_hold_no_issue"}, hd_valid_in, 0);
      check_output({tag, "_hold_disp"}, m_disparity, ed);
      check_output({tag, "_hold_cost"}, m_cost, ec);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    s_valid = 1'b0;
  endtask

  task automatic random_pixel();
    pix_left = 8'($urandom);
    for (int d = 0; d < MAX_DISP; d++) pix_right[d] = 8'($urandom);
  endtask

  initial begin
    rst            = 1'b1;
    s_valid        = 1'b0;
    m_ready        = 1'b0;
    s_census_left  = '0;
    s_census_right = '0;
    repeat (2) @(negedge clk);
    check_output("rst_s_ready", s_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check_output("rst_s_ready_after", s_ready, 1);
    check_output("rst_hd_valid_in", hd_valid_in, 0);
    check_output("rst_hd_left", hd_census_left, 0);
    check_output("rst_hd_right", hd_census_right, 0);
    check_output("rst_m_valid", m_valid, 0);
    check_output("rst_m_disp", m_disparity, 0);
    check_output("rst_m_cost", m_cost, 0);
    check_output("rst_m_invalid", m_invalid, 0);
    check_output("rst_err_drain", err_drain, 0);

    $display("[TB] tie keeps lowest disparity");
    pix_left = 8'($urandom);
    for (int d = 0; d < MAX_DISP; d++) pix_right[d] = pix_left;
    pix_right[5] = ~pix_left;
    apply_stimulus("tie_low", 0, 1'b1);

    $display("[TB] ramp with zero-cost candidate at 11");
    pix_left = 8'h00;
    for (int d = 0; d < MAX_DISP; d++) pix_right[d] = (d < 8) ? 8'((1 << d) - 1) : 8'hFF;
    pix_right[11] = 8'h00;
    apply_stimulus("ramp_a", 0, 1'b1);
    pix_right[0] = 8'h01;
    apply_stimulus("ramp_b", 0, 1'b1);

    $display("[TB] m_ready stall with pending request");
    random_pixel();
    apply_stimulus("stall", 10, 1'b1);
    random_pixel();
    apply_stimulus("after_stall", 0, 1'b1);

    $display("[TB] random back-to-back pixels");
    for (int k = 0; k < 5; k++) begin
      random_pixel();
      apply_stimulus("rand", 0, 1'b1);
    end

    $display("[TB] reset during ISSUE");
    random_pixel();
    s_valid       = 1'b1;
    s_census_left = pix_left;
    for (int d = 0; d < MAX_DISP; d++) s_census_right[d*CENSUS_WIDTH +: CENSUS_WIDTH] = pix_right[d];
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("midrst_hd_valid_in", hd_valid_in, 0);
    check_output("midrst_s_ready", s_ready, 1);
    check_output("midrst_m_valid", m_valid, 0);
    random_pixel();
    apply_stimulus("post_rst", 0, 1'b1);

    $display("[TB] drain watchdog");
    suppress_idx = MAX_DISP - 1;
    random_pixel();
    apply_stimulus("watchdog", 0, 1'b1);
    check_output("watchdog_err", err_drain, 1);
    suppress_idx = -1;
    random_pixel();
    apply_stimulus("sticky", 0, 1'b1);
    check_output("sticky_err", err_drain, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_output("err_cleared", err_drain, 0);

    $display("[TB] uniqueness margin");
    pix_left = 8'h00;
    for (int d = 0; d < MAX_DISP; d++) pix_right[d] = 8'hFF;
    pix_right[3] = 8'h03;
    pix_right[9] = 8'h03;
    apply_stimulus("uniq_tie", 0, 1'b1);
    pix_right[9] = 8'h0F;
    apply_stimulus("uniq_ok", 0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
